// File: rtl/pipe_sched.sv
// pipe_sched: pipeline sequencing, RAW/redirect/hold/drain control and bring-up counters for the 5-stage core
module pipe_sched #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [4:0]       rs1_addr_id_i,
    input  logic [4:0]       rs2_addr_id_i,
    input  logic             rs1_used_id_i,
    input  logic             rs2_used_id_i,
    input  logic [4:0]       rd_addr_id_i,
    input  logic             rd_wren_id_i,
    input  logic             br_sel_mem_i,
    input  logic             hold_i,
    input  logic             drain_req_i,
    output logic             pc_en_o,
    output logic             en_if_id_o,
    output logic             en_id_ex_o,
    output logic             en_ex_mem_o,
    output logic             en_mem_wb_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic             flush_ex_mem_o,
    output logic             flush_mem_wb_o,
    output logic             drained_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] retire_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);
    typedef enum logic [1:0] {INIT = 2'd0, RUN = 2'd1, HOLD = 2'd2, DRAIN = 2'd3} state_t;
    state_t     state;
    logic       init_q;
    logic       vld_id, vld_ex, vld_mem, vld_wb;
    logic       wren_ex, wren_mem, wren_wb;
    logic [4:0] rd_ex, rd_mem, rd_wb;
    logic       is_init, hold_act, hit1, hit2, haz, redir, stall_win, redir_win;
    // WB counts as a producer because the regfile does not bypass
    assign hit1 = rs1_used_id_i && (|rs1_addr_id_i) &&
                  ((vld_ex && wren_ex && rd_ex == rs1_addr_id_i) ||
                   (vld_mem && wren_mem && rd_mem == rs1_addr_id_i) ||
                   (vld_wb && wren_wb && rd_wb == rs1_addr_id_i));
    assign hit2 = rs2_used_id_i && (|rs2_addr_id_i) &&
                  ((vld_ex && wren_ex && rd_ex == rs2_addr_id_i) ||
                   (vld_mem && wren_mem && rd_mem == rs2_addr_id_i) ||
                   (vld_wb && wren_wb && rd_wb == rs2_addr_id_i));
    assign haz       = vld_id && (hit1 || hit2);
    assign redir     = vld_mem && br_sel_mem_i;
    assign is_init   = state == INIT;
    assign hold_act  = hold_i && !is_init;
    assign redir_win = redir && !is_init && !hold_act;
    assign stall_win = haz && !is_init && !hold_act && !redir;
    assign state_o   = state;
    assign drained_o = state == DRAIN && !(vld_id || vld_ex || vld_mem || vld_wb);
    always_comb begin
        pc_en_o        = 1'b1;
        en_if_id_o     = 1'b1;
        en_id_ex_o     = 1'b1;
        en_ex_mem_o    = 1'b1;
        en_mem_wb_o    = 1'b1;
        flush_if_id_o  = 1'b0;
        flush_id_ex_o  = 1'b0;
        flush_ex_mem_o = 1'b0;
        flush_mem_wb_o = 1'b0;
        if (is_init) begin
            pc_en_o        = 1'b0;
            flush_if_id_o  = 1'b1;
            flush_id_ex_o  = 1'b1;
            flush_ex_mem_o = 1'b1;
            flush_mem_wb_o = 1'b1;
        end else if (hold_act) begin
            pc_en_o     = 1'b0;
            en_if_id_o  = 1'b0;
            en_id_ex_o  = 1'b0;
            en_ex_mem_o = 1'b0;
            en_mem_wb_o = 1'b0;
        end else if (redir) begin
            flush_if_id_o  = 1'b1;
            flush_id_ex_o  = 1'b1;
            flush_ex_mem_o = 1'b1;
        end else if (haz) begin
            pc_en_o       = 1'b0;
            en_if_id_o    = 1'b0;
            flush_id_ex_o = 1'b1;
        end else if (state == DRAIN) begin
            pc_en_o       = 1'b0;
            flush_if_id_o = 1'b1;
        end
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state        <= INIT;
            init_q       <= 1'b0;
            vld_id       <= 1'b0;
            vld_ex       <= 1'b0;
            vld_mem      <= 1'b0;
            vld_wb       <= 1'b0;
            wren_ex      <= 1'b0;
            wren_mem     <= 1'b0;
            wren_wb      <= 1'b0;
            rd_ex        <= 5'd0;
            rd_mem       <= 5'd0;
            rd_wb        <= 5'd0;
            cycle_cnt_o  <= '0;
            retire_cnt_o <= '0;
            stall_cnt_o  <= '0;
            flush_cnt_o  <= '0;
        end else begin
            // init_q stretches INIT over one full cycle after reset release
            init_q <= 1'b1;
            case (state)
                INIT:    state <= init_q ? RUN : INIT;
                RUN:     state <= hold_i ? HOLD : (drain_req_i ? DRAIN : RUN);
                HOLD:    state <= hold_i ? HOLD : (drain_req_i ? DRAIN : RUN);
                default: state <= hold_i ? HOLD : (drain_req_i ? DRAIN : RUN);
            endcase
            if (en_if_id_o) vld_id <= !flush_if_id_o;
            if (en_id_ex_o) begin
                vld_ex  <= vld_id && !flush_id_ex_o;
                rd_ex   <= rd_addr_id_i;
                wren_ex <= rd_wren_id_i;
            end
            if (en_ex_mem_o) begin
                vld_mem  <= vld_ex && !flush_ex_mem_o;
                rd_mem   <= rd_ex;
                wren_mem <= wren_ex;
            end
            if (en_mem_wb_o) begin
                vld_wb  <= vld_mem && !flush_mem_wb_o;
                rd_wb   <= rd_mem;
                wren_wb <= wren_mem;
            end
            if (!is_init) cycle_cnt_o <= cycle_cnt_o + CNT_W'(1);
            if (vld_wb && en_mem_wb_o) retire_cnt_o <= retire_cnt_o + CNT_W'(1);
            if (stall_win) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (redir_win) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_sched.sv
// tb_pipe_sched: directed scenarios for pipe_sched with a queue of expected values checked each cycle
module tb_pipe_sched;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [4:0]  rs1_addr_id_i, rs2_addr_id_i, rd_addr_id_i;
    logic        rs1_used_id_i, rs2_used_id_i, rd_wren_id_i;
    logic        br_sel_mem_i, hold_i, drain_req_i;
    logic        pc_en_o, en_if_id_o, en_id_ex_o, en_ex_mem_o, en_mem_wb_o;
    logic        flush_if_id_o, flush_id_ex_o, flush_ex_mem_o, flush_mem_wb_o;
    logic        drained_o;
    logic [1:0]  state_o;
    logic [31:0] cycle_cnt_o, retire_cnt_o, stall_cnt_o, flush_cnt_o;

    localparam logic [31:0] C_INIT = 32'h0FF, C_HOLD = 32'h000, C_REDIR = 32'h1FE;
    localparam logic [31:0] C_HAZ = 32'h074, C_DRAIN = 32'h0F8, C_RUN = 32'h1F0;
    localparam int S_CTL = 0, S_ST = 1, S_DRN = 2, S_CYC = 3, S_RET = 4, S_STL = 5, S_FLS = 6;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;
    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc_n = 0;

    pipe_sched #(.CNT_W(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rs1_addr_id_i(rs1_addr_id_i), .rs2_addr_id_i(rs2_addr_id_i),
        .rs1_used_id_i(rs1_used_id_i), .rs2_used_id_i(rs2_used_id_i),
        .rd_addr_id_i(rd_addr_id_i), .rd_wren_id_i(rd_wren_id_i),
        .br_sel_mem_i(br_sel_mem_i), .hold_i(hold_i), .drain_req_i(drain_req_i),
        .pc_en_o(pc_en_o), .en_if_id_o(en_if_id_o), .en_id_ex_o(en_id_ex_o),
        .en_ex_mem_o(en_ex_mem_o), .en_mem_wb_o(en_mem_wb_o),
        .flush_if_id_o(flush_if_id_o), .flush_id_ex_o(flush_id_ex_o),
        .flush_ex_mem_o(flush_ex_mem_o), .flush_mem_wb_o(flush_mem_wb_o),
        .drained_o(drained_o), .state_o(state_o),
        .cycle_cnt_o(cycle_cnt_o), .retire_cnt_o(retire_cnt_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_CTL: return {23'd0, pc_en_o, en_if_id_o, en_id_ex_o, en_ex_mem_o, en_mem_wb_o,
                           flush_if_id_o, flush_id_ex_o, flush_ex_mem_o, flush_mem_wb_o};
            S_ST:  return {30'd0, state_o};
            S_DRN: return {31'd0, drained_o};
            S_CYC: return cycle_cnt_o;
            S_RET: return retire_cnt_o;
            S_STL: return stall_cnt_o;
            default: return flush_cnt_o;
        endcase
    endfunction

    task automatic want(input string tag, input int sel, input logic [31:0] v);
        exp_q.push_back('{tag, sel, v});
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk_i);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("c%0d_%s", cyc_n, e.tag), observe(e.sel), e.val);
        end
        @(posedge clk_i);
        #1;
        cyc_n++;
    endtask

    task automatic set_id(input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                          input logic u2, input logic [4:0] rd, input logic w);
        rs1_addr_id_i = r1;
        rs1_used_id_i = u1;
        rs2_addr_id_i = r2;
        rs2_used_id_i = u2;
        rd_addr_id_i  = rd;
        rd_wren_id_i  = w;
    endtask

    task automatic want_cnt(input logic [31:0] cyc, input logic [31:0] ret,
                            input logic [31:0] stl, input logic [31:0] fls);
        want("cycle_cnt", S_CYC, cyc);
        want("retire_cnt", S_RET, ret);
        want("stall_cnt", S_STL, stl);
        want("flush_cnt", S_FLS, fls);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        br_sel_mem_i = 1'b0;
        hold_i = 1'b0;
        drain_req_i = 1'b0;
        @(posedge clk_i);
        #1;
        want("rst_ctl", S_CTL, C_INIT);
        want("rst_state", S_ST, 32'd0);
        want("rst_drained", S_DRN, 32'd0);
        want_cnt(32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        rst_ni = 1'b1;
        cyc_n = 0;
        for (int i = 0; i < 2; i++) begin
            want("init_ctl", S_CTL, C_INIT);
            want("init_state", S_ST, 32'd0);
            tick();
        end
        want("run_ctl", S_CTL, C_RUN);
        want("run_state", S_ST, 32'd1);
        want_cnt(32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        for (int i = 3; i < 7; i++) begin
            want("fill_ctl", S_CTL, C_RUN);
            tick();
        end
        // c7: addi x5 ; c8..c11: add x6,x5,x5
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        want("addi_ctl", S_CTL, C_RUN);
        tick();
        set_id(5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1);
        for (int i = 0; i < 3; i++) begin
            want("raw_ctl", S_CTL, C_HAZ);
            tick();
        end
        want("raw_release_ctl", S_CTL, C_RUN);
        want_cnt(32'd9, 32'd5, 32'd3, 32'd0);
        tick();
        // c12: writer of x0 ; c13/c14: readers that must not stall
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        want("x0_wr_ctl", S_CTL, C_RUN);
        tick();
        set_id(5'd0, 1'b1, 5'd6, 1'b0, 5'd0, 1'b0);
        want("x0_rd_ctl", S_CTL, C_RUN);
        tick();
        set_id(5'd7, 1'b1, 5'd6, 1'b0, 5'd0, 1'b0);
        want("unused_ctl", S_CTL, C_RUN);
        tick();
        // c15: producer x9 ; c16 stall ; c17 taken branch overrides the stall
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
        want("nostall_cnt", S_STL, 32'd3);
        tick();
        set_id(5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1);
        want("raw2_ctl", S_CTL, C_HAZ);
        tick();
        br_sel_mem_i = 1'b1;
        want("redir_ctl", S_CTL, C_REDIR);
        tick();
        br_sel_mem_i = 1'b0;
        want("post_redir_ctl", S_CTL, C_RUN);
        want("post_redir_stall", S_STL, 32'd4);
        want("post_redir_flush", S_FLS, 32'd1);
        tick();
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        want("c19_retire", S_RET, 32'd10);
        tick();
        tick();
        tick();
        // c22..c25: hold with a redirect waiting in MEM
        hold_i = 1'b1;
        br_sel_mem_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            want("hold_ctl", S_CTL, C_HOLD);
            want("hold_state", S_ST, (i == 0) ? 32'd1 : 32'd2);
            tick();
        end
        hold_i = 1'b0;
        want("late_redir_ctl", S_CTL, C_REDIR);
        want("late_redir_state", S_ST, 32'd2);
        tick();
        br_sel_mem_i = 1'b0;
        want("after_hold_ctl", S_CTL, C_RUN);
        want("after_hold_state", S_ST, 32'd1);
        want_cnt(32'd25, 32'd11, 32'd4, 32'd2);
        tick();
        want("c28_retire", S_RET, 32'd12);
        tick();
        // c29: drain requested with ID..MEM about to hold 3 instructions
        drain_req_i = 1'b1;
        want("drain_req_ctl", S_CTL, C_RUN);
        want("drain_req_state", S_ST, 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            want("drain_ctl", S_CTL, C_DRAIN);
            want("drain_state", S_ST, 32'd3);
            want("drain_busy", S_DRN, 32'd0);
            if (i == 0) want("drain_retire0", S_RET, 32'd12);
            tick();
        end
        want("drained", S_DRN, 32'd1);
        want("drained_retire", S_RET, 32'd15);
        want("drained_ctl", S_CTL, C_DRAIN);
        tick();
        drain_req_i = 1'b0;
        want("undrain_ctl", S_CTL, C_DRAIN);
        want("undrain_drained", S_DRN, 32'd1);
        tick();
        want("resume_ctl", S_CTL, C_RUN);
        want("resume_state", S_ST, 32'd1);
        want("resume_drained", S_DRN, 32'd0);
        want_cnt(32'd34, 32'd15, 32'd4, 32'd2);
        tick();
        rst_ni = 1'b0;
        tick();
        want("rerst_ctl", S_CTL, C_INIT);
        want("rerst_state", S_ST, 32'd0);
        want("rerst_drained", S_DRN, 32'd0);
        want_cnt(32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_sched.md
# pipe_sched

Pipeline scheduler for the 5-stage non-forwarding RV32I core. It owns pipeline sequencing and replaces the stateless hazard/enable decode. It keeps a shadow valid/destination pipeline for ID/EX/MEM/WB and a per-stage scoreboard, and it runs an INIT/RUN/HOLD/DRAIN state machine. It drives the PC enable plus every stage-register enable and flush, and it keeps cycle, retire, stall and flush counters for bring-up.

## Interface
- CNT_W, 32, width of the performance counters
- clk_i  in  1  core clock
- rst_ni  in  1  reset; synchronous and active-low
- rs1_addr_id_i, rs2_addr_id_i  in  5  source registers of the instruction in ID
- rs1_used_id_i, rs2_used_id_i  in  1  the instruction in ID reads that source
- rd_addr_id_i  in  5  destination register of the instruction in ID
- rd_wren_id_i  in  1  the instruction in ID writes rd
- br_sel_mem_i  in  1  branch/jump taken in MEM; PC mux selects the target
- hold_i  in  1  external freeze request (level)
- drain_req_i  in  1  stop issuing and empty the pipe (level)
- pc_en_o  out  1  PC register loads nxt_pc
- en_if_id_o, en_id_ex_o, en_ex_mem_o, en_mem_wb_o  out  1  stage register enables
- flush_if_id_o, flush_id_ex_o, flush_ex_mem_o, flush_mem_wb_o  out  1  load a bubble when enabled
- drained_o  out  1  DRAIN state and the ID..WB shadow is empty
- state_o  out  2  encoding: 0 INIT, 1 RUN, 2 HOLD, 3 DRAIN
- cycle_cnt_o, retire_cnt_o, stall_cnt_o, flush_cnt_o  out  CNT_W  performance counters

## Operation
**Shadow pipeline**
- Holds vld_id, and for each of EX, MEM and WB: {vld, rd, wren}.
- It advances using exactly the enables and flushes driven out. A flushed stage becomes invalid.
- A stage's shadow valid qualifies that stage's inputs: br_sel_mem_i counts only when vld_mem=1.

**Data hazard (haz)**
- haz is raised when vld_id=1, a used source is nonzero, and that source equals the rd of any valid, wren EX/MEM/WB stage.
- WB is included because the regfile does not bypass.

**Redirect (redir)**
- redir = vld_mem & br_sel_mem_i.

**Output priority, highest first**
1. INIT
   - pc_en=0.
   - All stage enables=1 and all flushes=1.
2. HOLD (hold_i=1 in RUN or DRAIN)
   - All enables=0 and all flushes=0.
   - A pending redir stays latched in MEM and is taken after the hold releases.
3. redir
   - pc_en=1.
   - All enables=1.
   - flush_if_id, flush_id_ex and flush_ex_mem=1; flush_mem_wb=0.
   - Overrides haz.
4. haz
   - pc_en=0 and en_if_id=0.
   - en_id_ex=1 with flush_id_ex=1, which inserts a bubble.
   - EX/MEM and MEM/WB advance.
5. DRAIN without haz or redir
   - pc_en=0.
   - en_if_id=1 with flush_if_id=1. The instruction at PC is re-fetched after resume.
   - All other stages advance.
6. Normal RUN
   - All enables=1, all flushes=0, pc_en=1.

**FSM**
- Reset → INIT.
- INIT → RUN, unconditionally, after one cycle.
- RUN → HOLD if hold_i; else → DRAIN if drain_req_i.
- HOLD → RUN when hold_i=0 and drain_req_i=0; → DRAIN when hold_i=0 and drain_req_i=1.
- DRAIN → HOLD if hold_i; → RUN if drain_req_i=0.
- HOLD output behaviour applies in the same cycle hold_i rises. The state register follows on the next edge.

**Counters** (CNT_W bits, wrap modulo 2^CNT_W, all 0 after reset)
- cycle_cnt: increments every cycle outside INIT.
- retire_cnt: increments when vld_wb=1 and en_mem_wb=1.
- stall_cnt: increments on haz cycles where haz wins priority.
- flush_cnt: increments on redir cycles.

## Timing
- While rst_ni is sampled low:
  - state=INIT and all shadow valids=0.
  - Counters=0 and drained_o=0.
  - Outputs show INIT values: pc_en=0, all en=1, all flush=1.
- The first RUN cycle is the second edge after rst_ni rises. pc_en first rises in that cycle. This gives the existing one-cycle reset wait.
- All outputs are combinational from the registered state/shadow and the current inputs. There are no added register stages.
- Load-use / RAW penalty is 3 stall cycles when the producer sits directly ahead in EX. The consumer enters EX in the cycle after the producer leaves WB.
- Redirect penalty is 3 bubbles. The target instruction is in IF in the cycle after redir.
- hold_i and redir in the same cycle: hold wins and nothing moves.
- drained_o can assert no earlier than the 4th DRAIN cycle with no hold.

## Test plan
- Reset released at cycle 0 → INIT for 1 cycle; pc_en=0 in cycles 0-1 and 1 in cycle 2; all counters 0.
- addi x5 followed by add x6,x5,x5 → exactly 3 cycles with pc_en=0 and flush_id_ex=1; stall_cnt=3; add enters EX the cycle after addi leaves WB.
- Producer writing x0, or consumer with rs*_used=0 → no stall; stall_cnt unchanged.
- Taken branch (br_sel_mem_i=1 with vld_mem) while a RAW stall is active → redir wins; flush_if_id/id_ex/ex_mem=1 for one cycle; flush_cnt=1; the stall is dropped.
- hold_i pulsed for 4 cycles with a redir pending → all enables 0 for those 4 cycles; redir executes on the first cycle after release; cycle_cnt still +4.
- drain_req_i asserted with 3 instructions in flight → drained_o=1 after 4 cycles; retire_cnt +3; drain_req_i low → RUN and the fetch of the held PC resumes.
